// File: rtl/alu_sequencer_pkg.sv
// Shared ALU encodings: opcodes, flag bit positions, sequencer states.
// Latency: none (definitions only); backpressure: n/a.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_CP   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_BSL  = 4'd8;
    localparam logic [3:0] OP_BSR  = 4'd9;
    localparam logic [3:0] OP_SWAP = 4'd10;

    // First opcode value that the ALU does not implement.
    localparam logic [3:0] ILLEGAL_OP = 4'd11;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC_LO = 2'd1,
        ST_EXEC_HI = 2'd2,
        ST_WB      = 2'd3
    } state_e;

    function automatic logic is_arith(input logic [3:0] op);
        return op <= OP_SBC;
    endfunction

    // High byte of a wide add/sub must absorb the low byte's carry/borrow.
    function automatic logic [3:0] hi_pass_op(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            OP_ADD:  res = OP_ADC;
            OP_SUB:  res = OP_SBC;
            default: res = op;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences the shared ALU over one (narrow) or two (wide) byte passes, owns F.
// Latency: writeback 2 cycles (narrow) / 3 cycles (wide) after accept; req_ready only in IDLE.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic              req_wide,
    input  logic [15:0]       req_a,
    input  logic [15:0]       req_b,
    input  logic [TAG_W-1:0]  req_dst,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_carry_in,
    input  logic [15:0]       alu_res,
    input  logic [7:0]        alu_flags,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [15:0]       wb_data,
    output logic [TAG_W-1:0]  wb_dst,
    input  logic              f_load,
    input  logic [7:0]        f_load_data,
    output logic [7:0]        flags_q
);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               wide_q, wide_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic [TAG_W-1:0]   dst_q, dst_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         tmp_f_q, tmp_f_d;
    logic [7:0]         flags_d;

    logic               req_ready_q, req_ready_d;
    logic [15:0]        alu_a_q, alu_a_d;
    logic [15:0]        alu_b_q, alu_b_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic               alu_carry_in_q, alu_carry_in_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_we_q, wb_we_d;
    logic [15:0]        wb_data_q, wb_data_d;
    logic [TAG_W-1:0]   wb_dst_q, wb_dst_d;

    logic               legal_op;
    logic               unused_alu_bits;

    assign legal_op        = op_q < ILLEGAL_OP;
    assign unused_alu_bits = ^{alu_res[15:8], alu_flags[3:0]};

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        wide_d         = wide_q;
        a_d            = a_q;
        b_d            = b_q;
        dst_d          = dst_q;
        lo_d           = lo_q;
        tmp_f_d        = tmp_f_q;
        alu_a_d        = 16'h0000;
        alu_b_d        = 16'h0000;
        alu_op_d       = 4'd0;
        alu_carry_in_d = 1'b0;
        wb_valid_d     = 1'b0;
        wb_we_d        = 1'b0;
        wb_data_d      = wb_data_q;
        wb_dst_d       = wb_dst_q;
        flags_d        = f_load ? {f_load_data[7:4], 4'h0} : flags_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_EXEC_LO;
                    op_d     = req_op;
                    wide_d   = req_wide;
                    a_d      = req_a;
                    b_d      = req_b;
                    dst_d    = req_dst;
                    alu_a_d  = {8'h00, req_a[7:0]};
                    alu_b_d  = {8'h00, req_b[7:0]};
                    alu_op_d = req_op;
                    // flags_d so a simultaneous POP AF feeds the carry the EXEC_LO cycle sees.
                    alu_carry_in_d = (req_op == OP_ADC || req_op == OP_SBC) ? flags_d[FLAG_C] : 1'b0;
                end
            end
            ST_EXEC_LO: begin
                lo_d    = alu_res[7:0];
                tmp_f_d = alu_flags;
                if (wide_q) begin
                    state_d        = ST_EXEC_HI;
                    alu_a_d        = {8'h00, a_q[15:8]};
                    alu_b_d        = {8'h00, b_q[15:8]};
                    alu_op_d       = hi_pass_op(op_q);
                    alu_carry_in_d = is_arith(op_q) ? alu_flags[FLAG_C] : 1'b0;
                end else begin
                    state_d    = ST_WB;
                    wb_valid_d = 1'b1;
                    wb_we_d    = legal_op && (op_q != OP_CP);
                    wb_data_d  = legal_op ? {8'h00, alu_res[7:0]} : 16'h0000;
                    wb_dst_d   = dst_q;
                end
            end
            ST_EXEC_HI: begin
                tmp_f_d    = alu_flags;
                state_d    = ST_WB;
                wb_valid_d = 1'b1;
                wb_we_d    = legal_op && (op_q != OP_CP);
                wb_data_d  = legal_op ? {alu_res[7:0], lo_q} : 16'h0000;
                wb_dst_d   = dst_q;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                // Z of a wide op reflects only the high byte, so it is left as it was.
                if (legal_op) begin
                    flags_d = wide_q ? {flags_q[FLAG_Z], tmp_f_q[6:4], 4'h0}
                                     : {tmp_f_q[7:4], 4'h0};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= 4'd0;
            wide_q         <= 1'b0;
            a_q            <= 16'h0000;
            b_q            <= 16'h0000;
            dst_q          <= '0;
            lo_q           <= 8'h00;
            tmp_f_q        <= 8'h00;
            flags_q        <= 8'h00;
            req_ready_q    <= 1'b1;
            alu_a_q        <= 16'h0000;
            alu_b_q        <= 16'h0000;
            alu_op_q       <= 4'd0;
            alu_carry_in_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_we_q        <= 1'b0;
            wb_data_q      <= 16'h0000;
            wb_dst_q       <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            wide_q         <= wide_d;
            a_q            <= a_d;
            b_q            <= b_d;
            dst_q          <= dst_d;
            lo_q           <= lo_d;
            tmp_f_q        <= tmp_f_d;
            flags_q        <= flags_d;
            req_ready_q    <= req_ready_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            alu_carry_in_q <= alu_carry_in_d;
            wb_valid_q     <= wb_valid_d;
            wb_we_q        <= wb_we_d;
            wb_data_q      <= wb_data_d;
            wb_dst_q       <= wb_dst_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_carry_in = alu_carry_in_q;
    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign wb_data      = wb_data_q;
    assign wb_dst       = wb_dst_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural byte ALU plus a transaction-level reference model.
// Directed cases first, then randomized requests with random POP AF timing.
module tb_alu_sequencer;

    localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, SBC = 4'd3, CP = 4'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_wide;
    logic [15:0] req_a, req_b;
    logic [2:0]  req_dst;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_carry_in;
    logic [15:0] alu_res;
    logic [7:0]  alu_flags;
    logic        wb_valid, wb_we;
    logic [15:0] wb_data;
    logic [2:0]  wb_dst;
    logic        f_load;
    logic [7:0]  f_load_data;
    logic [7:0]  flags_q;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_f;

    always #5 clk = ~clk;

    alu_sequencer #(.TAG_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wide(req_wide),
        .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data), .wb_dst(wb_dst),
        .f_load(f_load), .f_load_data(f_load_data), .flags_q(flags_q)
    );

    // Byte ALU: returns {flags[7:0], result[7:0]}, flags Z N H C in bits 7..4.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        int s, hs, c;
        logic [7:0] r;
        logic n, h, cy;
        c  = (op == ADC || op == SBC) ? int'(cin) : 0;
        n  = 1'b0; h = 1'b0; cy = 1'b0; r = 8'h00;
        case (op)
            4'd0, 4'd1: begin
                s = int'(a) + int'(b) + c; hs = int'(a[3:0]) + int'(b[3:0]) + c;
                r = s[7:0]; h = hs > 15; cy = s > 255;
            end
            4'd2, 4'd3, 4'd4: begin
                s = int'(a) - int'(b) - c; hs = int'(a[3:0]) - int'(b[3:0]) - c;
                r = s[7:0]; n = 1'b1; h = hs < 0; cy = s < 0;
            end
            4'd5: begin r = a & b; h = 1'b1; end
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: begin r = {a[6:0], 1'b0}; cy = a[7]; end
            4'd9: begin r = {1'b0, a[7:1]}; cy = a[0]; end
            4'd10: r = {a[3:0], a[7:4]};
            default: r = 8'h00;
        endcase
        return {(r == 8'h00) && (op < 4'd11), n, h, cy, 4'h0, r};
    endfunction

    logic [15:0] alu_pack;
    assign alu_pack  = alu_fn(alu_op, alu_a[7:0], alu_b[7:0], alu_carry_in);
    assign alu_res   = {8'h00, alu_pack[7:0]};
    assign alu_flags = alu_pack[15:8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full request; fmode 0: no POP AF, 1: POP AF in the accept cycle, 2: POP AF in the WB cycle.
    task automatic do_op(input logic [3:0] op, input logic wide, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] dst, input int fmode,
                         input logic [7:0] fdat);
        logic [7:0]  f_pre, f_exp, lo_r, lo_f, hi_r, hi_f;
        logic [3:0]  hop;
        logic [15:0] t;
        logic        legal, cin_lo, cin_hi, we_exp;
        legal  = op < 4'd11;
        we_exp = legal && op != CP;
        f_pre  = (fmode == 1) ? {fdat[7:4], 4'h0} : model_f;
        cin_lo = (op == ADC || op == SBC) ? f_pre[4] : 1'b0;
        t = alu_fn(op, a[7:0], b[7:0], cin_lo);
        lo_r = t[7:0]; lo_f = t[15:8];
        hop = (op == ADD) ? ADC : (op == SUB) ? SBC : op;
        cin_hi = (op <= SBC) ? lo_f[4] : 1'b0;
        t = alu_fn(hop, a[15:8], b[15:8], cin_hi);
        hi_r = t[7:0]; hi_f = t[15:8];
        if (!legal)
            f_exp = (fmode == 2) ? {fdat[7:4], 4'h0} : f_pre;
        else if (wide)
            f_exp = {f_pre[7], hi_f[6:4], 4'h0};
        else
            f_exp = {lo_f[7:4], 4'h0};

        @(negedge clk);
        check_val("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_wide = wide; req_a = a; req_b = b; req_dst = dst;
        if (fmode == 1) begin f_load = 1'b1; f_load_data = fdat; end
        @(negedge clk);
        req_valid = 1'b0; f_load = 1'b0;
        check_val("ready_lo", req_ready, 0);
        check_val("wbv_lo", wb_valid, 0);
        if (legal) begin
            check_val("alu_a_lo", alu_a, {8'h00, a[7:0]});
            check_val("alu_b_lo", alu_b, {8'h00, b[7:0]});
            check_val("alu_op_lo", alu_op, op);
            check_val("cin_lo", alu_carry_in, cin_lo);
        end
        if (wide) begin
            @(negedge clk);
            check_val("ready_hi", req_ready, 0);
            check_val("wbv_hi", wb_valid, 0);
            if (legal) begin
                check_val("alu_a_hi", alu_a, {8'h00, a[15:8]});
                check_val("alu_b_hi", alu_b, {8'h00, b[15:8]});
                check_val("alu_op_hi", alu_op, hop);
                check_val("cin_hi", alu_carry_in, cin_hi);
            end
        end
        @(negedge clk);
        check_val("wb_valid", wb_valid, 1);
        check_val("ready_wb", req_ready, 0);
        check_val("wb_we", wb_we, we_exp);
        check_val("wb_dst", wb_dst, dst);
        if (legal) check_val("wb_data", wb_data, {wide ? hi_r : 8'h00, lo_r});
        if (fmode == 2) begin f_load = 1'b1; f_load_data = fdat; end
        @(negedge clk);
        f_load = 1'b0;
        check_val("wbv_after", wb_valid, 0);
        check_val("ready_after", req_ready, 1);
        check_val("flags", flags_q, f_exp);
        model_f = f_exp;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_wide = 1'b0;
        req_a = 16'h0; req_b = 16'h0; req_dst = 3'd0; f_load = 1'b0; f_load_data = 8'h0;
        model_f = 8'h00;
        repeat (2) @(negedge clk);
        check_val("rst_ready", req_ready, 1);
        check_val("rst_wbv", wb_valid, 0);
        check_val("rst_we", wb_we, 0);
        check_val("rst_data", wb_data, 0);
        check_val("rst_dst", wb_dst, 0);
        check_val("rst_flags", flags_q, 0);
        check_val("rst_alu", {alu_a, alu_b, alu_op, alu_carry_in}, 0);
        rst_n = 1'b1;

        do_op(ADD, 1'b0, 16'h003A, 16'h00C6, 3'd1, 0, 8'h00);
        do_op(ADC, 1'b0, 16'h00E1, 16'h000F, 3'd2, 1, 8'h10);
        do_op(ADD, 1'b1, 16'h8A23, 16'h0605, 3'd3, 1, 8'h80);
        do_op(CP,  1'b0, 16'h003C, 16'h003C, 3'd4, 2, 8'h50);
        do_op(4'd12, 1'b0, 16'h1234, 16'h5678, 3'd5, 2, 8'hFF);
        do_op(4'd15, 1'b1, 16'hFFFF, 16'h0001, 3'd6, 0, 8'h00);

        // Reset during EXEC_HI of a wide op: abort, no writeback, F cleared.
        @(negedge clk);
        req_valid = 1'b1; req_op = SUB; req_wide = 1'b1; req_a = 16'h1000; req_b = 16'h0001; req_dst = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_val("rst_mid_ready", req_ready, 0);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_flags", flags_q, 0);
        check_val("rst_mid_wbv", wb_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("rst_post_wbv", wb_valid, 0);
            check_val("rst_post_ready", req_ready, 1);
        end
        check_val("rst_post_flags", flags_q, 0);
        model_f = 8'h00;

        // Back-to-back with req_valid held: ADD then ADC consuming its carry.
        @(negedge clk);
        req_valid = 1'b1; req_op = ADD; req_wide = 1'b0; req_a = 16'h00FF; req_b = 16'h0001; req_dst = 3'd1;
        @(negedge clk);
        check_val("b2b_ready1", req_ready, 0);
        req_op = ADC; req_a = 16'h0010; req_b = 16'h0020; req_dst = 3'd2;
        @(negedge clk);
        check_val("b2b_ready2", req_ready, 0);
        check_val("b2b_wbv1", wb_valid, 1);
        check_val("b2b_data1", wb_data, 16'h0000);
        @(negedge clk);
        check_val("b2b_ready3", req_ready, 1);
        check_val("b2b_flags1", flags_q, 8'hB0);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("b2b_ready4", req_ready, 0);
        check_val("b2b_op2", alu_op, ADC);
        check_val("b2b_cin2", alu_carry_in, 1);
        @(negedge clk);
        check_val("b2b_wbv2", wb_valid, 1);
        check_val("b2b_data2", wb_data, 16'h0031);
        check_val("b2b_dst2", wb_dst, 2);
        @(negedge clk);
        check_val("b2b_flags2", flags_q, 8'h00);
        model_f = 8'h00;

        for (int i = 0; i < 200; i++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            do_op(rop, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequences the shared 16-bit ALU for decoded arithmetic/logic requests from the instruction decoder.
- Owns the F (flags) register.
- Runs narrow (8-bit) ops in one ALU pass and wide (16-bit) ops as two byte passes, chaining the carry between them.
- Returns the result and a destination tag to the register file through a one-cycle writeback pulse.

Parameters:
- TAG_W, 3, width of the destination register tag carried through to writeback

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  decoder presents a request
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  4  ALU opcode: ADD=0, ADC=1, SUB=2, SBC=3, CP=4, AND=5, OR=6, XOR=7, BSL=8, BSR=9, SWAP=10
- req_wide  in  1  1 = 16-bit op executed as two byte passes
- req_a  in  16  operand A
- req_b  in  16  operand B
- req_dst  in  TAG_W  destination tag
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_op  out  4  ALU opcode
- alu_carry_in  out  1  ALU carry input
- alu_res  in  16  ALU result, combinational, same cycle
- alu_flags  in  8  ALU flags: Z=7, N=6, H=5, C=4
- wb_valid  out  1  one-cycle writeback pulse
- wb_we  out  1  result is to be written; 0 for CP and illegal opcodes
- wb_data  out  16  result; upper byte 0 for narrow ops
- wb_dst  out  TAG_W  destination tag
- f_load  in  1  external F write (POP AF)
- f_load_data  in  8  data for the external F write
- flags_q  out  8  F register; bits 3:0 always 0

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, req_ready=1, wb_valid=0, wb_we=0
  - wb_data=0, wb_dst=0, flags_q=0x00
  - alu_a=alu_b=0, alu_op=0, alu_carry_in=0
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch op, operands, wide and dst; go to EXEC_LO.
  - EXEC_LO: alu_a={8'h00,a[7:0]}, alu_b={8'h00,b[7:0]}, alu_op=op.
    - alu_carry_in=flags_q[4] for ADC/SBC, else 0.
    - Sample alu_res[7:0] into lo_q and alu_flags into tmp_f at the end of the cycle.
    - Next state: EXEC_HI if wide, else WB.
  - EXEC_HI: operands are the high bytes, zero-extended.
    - alu_op: ADD->ADC, SUB->SBC, all other ops unchanged.
    - alu_carry_in=tmp_f[4] for the arithmetic ops (0-3), else 0.
    - Sample hi_q and tmp_f; go to WB.
  - WB: wb_valid=1 for one cycle; wb_data={hi_q,lo_q} (hi_q=0 when narrow); F updated; go to IDLE.
- Latency: request accepted at cycle T; narrow wb_valid at T+2, wide at T+3. Throughput is one request per 3 (narrow) or 4 (wide) cycles.
- Flag rules:
  - Narrow: F <= {tmp_f[7:4], 4'h0}.
  - Wide: Z preserved from flags_q; N, H, C taken from the high pass; low nibble 0.
  - CP: flags updated, wb_we=0.
- Illegal opcode (11-15): request is accepted, no ALU result is used, wb_valid pulses with wb_we=0, F unchanged.
- f_load:
  - Applied next edge as {f_load_data[7:4], 4'h0}, in any state.
  - Same cycle as a WB flag update: the WB update wins and the external write is dropped.
- req_valid while not ready is ignored; the decoder holds the request.
- Reset asserted mid-operation: the operation is aborted, no writeback occurs, F is cleared. req_ready is high on the first edge after rst_n deasserts.
- The ALU's 16-bit width is used only as byte lanes. Upper operand bits are always driven 0.

Decomposition:
- Shared package holds:
  - opcode localparams (ADD..SWAP, shared with alu)
  - flag bit indices (Z=7, N=6, H=5, C=4)
  - state encoding (IDLE, EXEC_LO, EXEC_HI, WB)
  - the ILLEGAL_OP boundary (11)
- No sub-module. The F register stays inline; the ALU is instantiated by the parent, not inside this block.

Test Plan:
- Narrow ADD, a=0x003A, b=0x00C6, F=0x00 -> wb_valid at T+2, wb_data=0x0000, wb_we=1, flags_q=0xB0.
- Narrow ADC with F=0x10, a=0x00E1, b=0x000F -> wb_data=0x00F1, flags_q=0x20; alu_carry_in=1 during EXEC_LO.
- Wide ADD with F=0x80, a=0x8A23, b=0x0605 -> EXEC_HI alu_op=ADC, alu_carry_in=0; wb_valid at T+3, wb_data=0x9028, flags_q=0xA0 (Z preserved).
- CP, a=0x003C, b=0x003C -> wb_valid=1, wb_we=0, flags_q=0xC0; f_load issued in the same WB cycle is dropped.
- Reset pulse during EXEC_HI of a wide op -> no wb_valid ever, flags_q=0x00, req_ready=1 after release.
- Back-to-back: req_valid held with ADD then ADC -> second accepted 3 cycles after the first; ADC uses the C flag produced by the first; req_ready low in EXEC_LO/EXEC_HI/WB.
